// File: rtl/ram_port_arbiter_pkg.sv
// ram_port_arbiter_pkg: shared memory geometry, arbiter FSM states and counter sizing helper.
package ram_port_arbiter_pkg;
  localparam int MEM_AW = 12;
  localparam int MEM_DW = 16;
  localparam int MEM_WORDS = 1 << MEM_AW;
  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_e;
  function automatic int cnt_w(input int max_wait);
    return max_wait < 1 ? 1 : $clog2(max_wait + 1);
  endfunction
endpackage

// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: CPU, DMA and memory-side signals of the RAM port arbiter.
interface ram_port_arbiter_if #(
  parameter int AW = ram_port_arbiter_pkg::MEM_AW,
  parameter int DW = ram_port_arbiter_pkg::MEM_DW
);
  logic          cpu_str;
  logic          cpu_load;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_rvalid;
  logic          cpu_hold;
  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_ack;
  logic [DW-1:0] dma_rdata;
  logic          dma_rvalid;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          proto_err;
  modport slave (
    input  cpu_str, cpu_load, cpu_addr, cpu_wdata, dma_req, dma_we, dma_addr, dma_wdata, mem_rdata,
    output cpu_rdata, cpu_rvalid, cpu_hold, dma_ack, dma_rdata, dma_rvalid,
    output mem_en, mem_we, mem_addr, mem_wdata, proto_err
  );
  modport master (
    output cpu_str, cpu_load, cpu_addr, cpu_wdata, dma_req, dma_we, dma_addr, dma_wdata, mem_rdata,
    input  cpu_rdata, cpu_rvalid, cpu_hold, dma_ack, dma_rdata, dma_rvalid,
    input  mem_en, mem_we, mem_addr, mem_wdata, proto_err
  );
endinterface

// File: rtl/ram_wait_counter.sv
// ram_wait_counter: saturating DMA wait counter; at_max flags the cycle the count reaches MAX_WAIT.
module ram_wait_counter
  import ram_port_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  output logic at_max
);
  localparam int W = cnt_w(MAX_WAIT);
  logic [W-1:0] count_d, count_q;
  // at_max looks at the next count so the hold lands right after the MAX_WAIT-th unserved cycle
  always_comb begin
    count_d = !inc ? '0 : count_q == W'(MAX_WAIT) ? count_q : count_q + 1'b1;
    at_max = MAX_WAIT != 0 && count_d == W'(MAX_WAIT);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count_q <= '0;
    else count_q <= count_d;
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares the single RAM port between CPU strobes (fixed priority) and a DMA requester,
// freezing the CPU for one cycle when the DMA has waited MAX_WAIT cycles.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int AW = MEM_AW,
  parameter int DW = MEM_DW,
  parameter int MAX_WAIT = 8
) (
  input logic clk,
  input logic rst_n,
  ram_port_arbiter_if.slave bus
);
  state_e        state_q;
  logic          hold_q, at_max, cpu_go, dma_go;
  logic [AW-1:0] addr_d, addr_q;
  logic [DW-1:0] wdata_d, wdata_q, cpu_rdata_d, cpu_rdata_q, dma_rdata_d, dma_rdata_q;
  logic          cpu_rv_d, cpu_rv_q, dma_rv_d, dma_rv_q, err_d, err_q;
  ram_wait_counter #(.MAX_WAIT(MAX_WAIT)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (bus.dma_req & ~dma_go),
    .at_max(at_max)
  );
  // grants are gated by rst_n so every output is quiet while reset is held
  always_comb begin
    cpu_go = rst_n & (bus.cpu_str | bus.cpu_load) & ~hold_q;
    dma_go = rst_n & ~cpu_go & bus.dma_req;
    addr_d = cpu_go ? bus.cpu_addr : dma_go ? bus.dma_addr : addr_q;
    wdata_d = cpu_go ? bus.cpu_wdata : dma_go ? bus.dma_wdata : wdata_q;
    cpu_rv_d = cpu_go & ~bus.cpu_str;
    dma_rv_d = dma_go & ~bus.dma_we;
    cpu_rdata_d = cpu_rv_q ? bus.mem_rdata : cpu_rdata_q;
    dma_rdata_d = dma_rv_q ? bus.mem_rdata : dma_rdata_q;
    err_d = err_q | (bus.cpu_str & bus.cpu_load);
  end
  assign bus.mem_en = cpu_go | dma_go;
  assign bus.mem_we = cpu_go ? bus.cpu_str : dma_go & bus.dma_we;
  assign bus.mem_addr = addr_d;
  assign bus.mem_wdata = wdata_d;
  assign bus.dma_ack = dma_go;
  assign bus.cpu_hold = hold_q;
  assign bus.cpu_rvalid = cpu_rv_q;
  assign bus.cpu_rdata = cpu_rdata_d;
  assign bus.dma_rvalid = dma_rv_q;
  assign bus.dma_rdata = dma_rdata_d;
  assign bus.proto_err = err_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q <= 1'b0;
    end else begin
      state_q <= state_q == HOLD ? IDLE : at_max ? HOLD : bus.dma_req & ~dma_go ? WAIT : IDLE;
      hold_q <= state_q != HOLD & at_max;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr_q <= '0;
      wdata_q <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      cpu_rv_q <= 1'b0;
      dma_rv_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
      cpu_rv_q <= cpu_rv_d;
      dma_rv_q <= dma_rv_d;
      err_q <= err_d;
    end
endmodule
